// File: rtl/pipe_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline field widths, bit positions and ALU encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_REG_AW   = 5;
   localparam int STALL_CNT_W  = 16;

   localparam int WB_W         = 2;
   localparam int M_W          = 2;
   localparam int EX_W         = 5;

   localparam int WB_REGWRITE  = 1;
   localparam int WB_MEM2REG   = 0;
   localparam int M_READ       = 1;
   localparam int M_WRITE      = 0;
   localparam int EX_REGDST    = 0;
   localparam int EX_ALUSRC    = 1;
   localparam int EX_ALUOP_LO  = 2;
   localparam int EX_ALUOP_HI  = 4;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } alu_op_e;

   function automatic logic is_load(input logic [M_W-1:0] m);
      return m[M_READ];
   endfunction

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector; flush suppresses stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
   import pipe_pkg::*;
#(
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              ex_valid,
   input  logic [M_W-1:0]    ex_m,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              flush,
   output logic              stall
);

   logic w_ex_load;
   logic w_src_match;

   // A load into $0 never produces a value worth waiting for.
   assign w_ex_load   = ex_valid & is_load(ex_m) & (ex_rt != '0);
   assign w_src_match = (ex_rt == id_rs) | (ex_rt == id_rt);
   assign stall       = w_ex_load & id_valid & w_src_match & ~flush;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use stall and flush bubble.
//               Optional stall counter enabled by ID_EX_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [WB_W-1:0]   id_wb,
   input  logic [M_W-1:0]    id_m,
   input  logic [EX_W-1:0]   id_ex,
   input  logic              flush,
   output logic              ex_valid,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [WB_W-1:0]   ex_wb,
   output logic [M_W-1:0]    ex_m,
   output logic [EX_W-1:0]   ex_ctl,
   output logic              stall,
   output logic              pc_write,
   output logic              if_id_write
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   logic w_stall;
   logic w_bubble;

   load_use_detect #(
      .REG_AW (REG_AW)
   ) u_load_use_detect (
      .ex_valid (ex_valid),
      .ex_m     (ex_m),
      .ex_rt    (ex_rt),
      .id_valid (id_valid),
      .id_rs    (id_rs),
      .id_rt    (id_rt),
      .flush    (flush),
      .stall    (w_stall)
   );

   assign stall       = w_stall;
   assign pc_write    = ~w_stall;
   assign if_id_write = ~w_stall;

   // Flush and stall both inject a fully zeroed bubble so forwarding sees rs=rt=0.
   assign w_bubble = flush | w_stall;

   always_ff @(posedge clk) begin
      if (rst || w_bubble) begin
         ex_valid <= 1'b0;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_wb    <= '0;
         ex_m     <= '0;
         ex_ctl   <= '0;
      end else begin
         ex_valid <= id_valid;
         ex_rs    <= id_rs;
         ex_rt    <= id_rt;
         ex_rd    <= id_rd;
         ex_rd1   <= id_rd1;
         ex_rd2   <= id_rd2;
         ex_imm   <= id_imm;
         ex_wb    <= id_wb;
         ex_m     <= id_m;
         ex_ctl   <= id_ex;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rd1, id_rd2, id_imm;
   logic [1:0]  id_wb, id_m;
   logic [4:0]  id_ex;
   logic        flush;
   logic        ex_valid;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_rd1, ex_rd2, ex_imm;
   logic [1:0]  ex_wb, ex_m;
   logic [4:0]  ex_ctl;
   logic        stall, pc_write, if_id_write;
`ifdef ID_EX_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_rd1      (id_rd1),
      .id_rd2      (id_rd2),
      .id_imm      (id_imm),
      .id_wb       (id_wb),
      .id_m        (id_m),
      .id_ex       (id_ex),
      .flush       (flush),
      .ex_valid    (ex_valid),
      .ex_rs       (ex_rs),
      .ex_rt       (ex_rt),
      .ex_rd       (ex_rd),
      .ex_rd1      (ex_rd1),
      .ex_rd2      (ex_rd2),
      .ex_imm      (ex_imm),
      .ex_wb       (ex_wb),
      .ex_m        (ex_m),
      .ex_ctl      (ex_ctl),
      .stall       (stall),
      .pc_write    (pc_write),
      .if_id_write (if_id_write)
`ifdef ID_EX_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [1:0] wb, input logic [1:0] m,
                         input logic [4:0] ex);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rd1 = d1; id_rd2 = d2; id_imm = imm;
      id_wb = wb; id_m = m; id_ex = ex;
   endtask

   task automatic idle(input int n);
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 5'd0);
      repeat (n) tick();
   endtask

   // Places a load with destination rt into EX.
   task automatic load_into_ex(input logic [4:0] rt);
      set_id(1'b1, 5'd1, rt, 5'd0, 32'h5, 32'h6, 32'h10, 2'b11, 2'b10, 5'b00010);
      tick();
   endtask

   task automatic test_reset();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
      checks++; if ({ex_rs, ex_rt, ex_rd} !== 15'd0) begin errors++; $display("FAIL reset_idx: got %h want 0", {ex_rs, ex_rt, ex_rd}); end
      checks++; if ({ex_rd1, ex_rd2, ex_imm} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {ex_rd1, ex_rd2, ex_imm}); end
      checks++; if ({ex_wb, ex_m, ex_ctl} !== 9'd0) begin errors++; $display("FAIL reset_ctl: got %h want 0", {ex_wb, ex_m, ex_ctl}); end
      checks++; if ({stall, pc_write, if_id_write} !== 3'b011) begin errors++; $display("FAIL reset_hazard: got %b want 011", {stall, pc_write, if_id_write}); end
`ifdef ID_EX_STALL_CNT_EN
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
`endif
   endtask

   task automatic test_plain();
      set_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h33, 2'b10, 2'b00, 5'b01110);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL plain_stall_id: got %0b want 0", stall); end
      tick();
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL plain_valid: got %0b want 1", ex_valid); end
      checks++; if ({ex_rs, ex_rt, ex_rd} !== {5'd3, 5'd4, 5'd5}) begin errors++; $display("FAIL plain_idx: got %h want %h", {ex_rs, ex_rt, ex_rd}, {5'd3, 5'd4, 5'd5}); end
      checks++; if ({ex_rd1, ex_rd2, ex_imm} !== {32'h11, 32'h22, 32'h33}) begin errors++; $display("FAIL plain_data: got %h want 11/22/33", {ex_rd1, ex_rd2, ex_imm}); end
      checks++; if ({ex_wb, ex_m, ex_ctl} !== {2'b10, 2'b00, 5'b01110}) begin errors++; $display("FAIL plain_ctl: got %b want 10_00_01110", {ex_wb, ex_m, ex_ctl}); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL plain_stall_ex: got %0b want 0", stall); end
      idle(2);
   endtask

   task automatic test_load_use();
      load_into_ex(5'd8);
      set_id(1'b1, 5'd8, 5'd2, 5'd9, 32'hAA, 32'hBB, 32'hCC, 2'b10, 2'b00, 5'b00101);
      #1;
      checks++; if ({stall, pc_write, if_id_write} !== 3'b100) begin errors++; $display("FAIL lu_stall: got %b want 100", {stall, pc_write, if_id_write}); end
      tick();
      checks++; if ({ex_valid, ex_wb, ex_m, ex_ctl} !== 10'd0) begin errors++; $display("FAIL lu_bubble_ctl: got %h want 0", {ex_valid, ex_wb, ex_m, ex_ctl}); end
      checks++; if ({ex_rs, ex_rt, ex_rd1} !== 42'd0) begin errors++; $display("FAIL lu_bubble_data: got %h want 0", {ex_rs, ex_rt, ex_rd1}); end
      checks++; if ({stall, pc_write} !== 2'b01) begin errors++; $display("FAIL lu_release: got %b want 01", {stall, pc_write}); end
      tick();
      checks++; if ({ex_valid, ex_rs, ex_rt, ex_rd} !== {1'b1, 5'd8, 5'd2, 5'd9}) begin errors++; $display("FAIL lu_held_idx: got %h want %h", {ex_valid, ex_rs, ex_rt, ex_rd}, {1'b1, 5'd8, 5'd2, 5'd9}); end
      checks++; if ({ex_rd1, ex_rd2, ex_ctl} !== {32'hAA, 32'hBB, 5'b00101}) begin errors++; $display("FAIL lu_held_data: got %h want AA/BB/05", {ex_rd1, ex_rd2, ex_ctl}); end
      idle(2);
   endtask

   task automatic test_no_false_stall();
      load_into_ex(5'd0);
      set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h1, 32'h2, 32'h3, 2'b10, 2'b00, 5'd0);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfs_r0: got %0b want 0", stall); end
      idle(2);
      load_into_ex(5'd8);
      set_id(1'b1, 5'd9, 5'd10, 5'd3, 32'h1, 32'h2, 32'h3, 2'b10, 2'b00, 5'd0);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfs_nodep: got %0b want 0", stall); end
      set_id(1'b0, 5'd8, 5'd8, 5'd3, 32'h1, 32'h2, 32'h3, 2'b10, 2'b00, 5'd0);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfs_id_invalid: got %0b want 0", stall); end
      // Store in ID whose rt matches the load destination must stall.
      set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h1, 32'h2, 32'h3, 2'b00, 2'b01, 5'b00010);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_rt_stall: got %0b want 1", stall); end
      idle(2);
      // A store in EX never causes a stall.
      set_id(1'b1, 5'd1, 5'd8, 5'd0, 32'h1, 32'h2, 32'h3, 2'b00, 2'b01, 5'b00010);
      tick();
      set_id(1'b1, 5'd8, 5'd8, 5'd4, 32'h1, 32'h2, 32'h3, 2'b10, 2'b00, 5'd0);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_in_ex: got %0b want 0", stall); end
      idle(2);
   endtask

   task automatic test_flush_wins();
      load_into_ex(5'd8);
      set_id(1'b1, 5'd8, 5'd2, 5'd9, 32'hAA, 32'hBB, 32'hCC, 2'b10, 2'b00, 5'b00101);
      flush = 1'b1;
      #1;
      checks++; if ({stall, pc_write} !== 2'b01) begin errors++; $display("FAIL flush_stall: got %b want 01", {stall, pc_write}); end
      tick();
      flush = 1'b0;
      checks++; if ({ex_valid, ex_rs, ex_rt, ex_m} !== 13'd0) begin errors++; $display("FAIL flush_bubble: got %h want 0", {ex_valid, ex_rs, ex_rt, ex_m}); end
      idle(2);
   endtask

   task automatic test_back_to_back();
      load_into_ex(5'd8);
      set_id(1'b1, 5'd8, 5'd9, 5'd0, 32'h7, 32'h0, 32'h4, 2'b11, 2'b10, 5'b00010);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_first: got %0b want 1", stall); end
      tick();
      tick();
      checks++; if ({ex_valid, ex_rt, ex_m} !== {1'b1, 5'd9, 2'b10}) begin errors++; $display("FAIL b2b_load2: got %h want %h", {ex_valid, ex_rt, ex_m}, {1'b1, 5'd9, 2'b10}); end
      set_id(1'b1, 5'd9, 5'd3, 5'd4, 32'h1, 32'h2, 32'h3, 2'b10, 2'b00, 5'd0);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_second: got %0b want 1", stall); end
      idle(2);
   endtask

   task automatic test_reset_mid_stall();
      load_into_ex(5'd8);
      set_id(1'b1, 5'd8, 5'd2, 5'd9, 32'hAA, 32'hBB, 32'hCC, 2'b10, 2'b00, 5'b00101);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre: got %0b want 1", stall); end
      rst = 1'b1;
      tick();
      checks++; if ({ex_valid, ex_rs, ex_rt, ex_rd, ex_wb, ex_m, ex_ctl} !== 25'd0) begin errors++; $display("FAIL rms_regs: got %h want 0", {ex_valid, ex_rs, ex_rt, ex_rd, ex_wb, ex_m, ex_ctl}); end
      checks++; if ({ex_rd1, ex_rd2, ex_imm} !== 96'd0) begin errors++; $display("FAIL rms_data: got %h want 0", {ex_rd1, ex_rd2, ex_imm}); end
      checks++; if ({stall, pc_write, if_id_write} !== 3'b011) begin errors++; $display("FAIL rms_hazard: got %b want 011", {stall, pc_write, if_id_write}); end
      rst = 1'b0;
      idle(2);
   endtask

`ifdef ID_EX_STALL_CNT_EN
   task automatic test_stall_cnt();
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL cnt_start: got %0d want 0", stall_cnt); end
      for (int i = 0; i < 3; i++) begin
         load_into_ex(5'd12);
         set_id(1'b1, 5'd2, 5'd12, 5'd6, 32'h1, 32'h2, 32'h3, 2'b10, 2'b00, 5'd0);
         tick();
         idle(2);
      end
      checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL cnt_three: got %0d want 3", stall_cnt); end
   endtask
`endif

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 5'd0);
      repeat (3) tick();
      test_reset();
      rst = 1'b0;
      idle(1);
      test_plain();
      test_load_use();
      test_no_false_stall();
      test_flush_wins();
      test_back_to_back();
      test_reset_mid_stall();
`ifdef ID_EX_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
